// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - run/pause/lap/clear controller for a two-digit BCD stopwatch counter
module stopwatch_ctrl #(
    parameter int unsigned TICK_DIV = 100000000,
    parameter bit          WRAP     = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start_stop,
    input  logic       btn_lap,
    input  logic       btn_clear,
    input  logic [3:0] cnt_q1,
    input  logic [3:0] cnt_q10,
    output logic       cnt_en,
    output logic       cnt_rst,
    output logic [3:0] disp_q1,
    output logic [3:0] disp_q10,
    output logic       running,
    output logic       lap_active,
    output logic       done
);

    localparam int unsigned      DIV_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_LAP,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [7:0]       lap_q, lap_d;
    logic             cnt_rst_q, cnt_rst_d;
    logic             ss_prev_q, lap_prev_q, clr_prev_q;

    logic press_ss, press_lap, press_clr;
    logic counting, terminal, at_last;

    assign press_ss  = btn_start_stop & ~ss_prev_q;
    assign press_lap = btn_lap & ~lap_prev_q;
    assign press_clr = btn_clear & ~clr_prev_q;

    assign counting = (state_q == S_RUN) || (state_q == S_LAP);
    assign terminal = !WRAP && (cnt_q10 == 4'd9) && (cnt_q1 == 4'd9);
    assign at_last  = (div_q == DIV_LAST);

    // Previous-value registers load the live button even in reset, so a held button never reads as a press.
    always_ff @(posedge clk) begin
        ss_prev_q  <= btn_start_stop;
        lap_prev_q <= btn_lap;
        clr_prev_q <= btn_clear;
        if (rst) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            lap_q     <= 8'h00;
            cnt_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            lap_q     <= lap_d;
            cnt_rst_q <= cnt_rst_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        lap_d     = lap_q;
        cnt_rst_d = 1'b0;

        if (counting) begin
            div_d = at_last ? '0 : div_q + 1'b1;
        end

        if (press_clr) begin
            state_d   = S_IDLE;
            div_d     = '0;
            lap_d     = 8'h00;
            cnt_rst_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE:  if (press_ss) state_d = S_RUN;
                S_PAUSE: if (press_ss) state_d = S_RUN;
                S_RUN: begin
                    if (press_ss) begin
                        state_d = S_PAUSE;
                    end else if (press_lap) begin
                        state_d = S_LAP;
                        lap_d   = {cnt_q10, cnt_q1};
                    end else if (terminal) begin
                        state_d = S_DONE;
                    end
                end
                S_LAP: begin
                    if (press_ss)       state_d = S_PAUSE;
                    else if (press_lap) state_d = S_RUN;
                    else if (terminal)  state_d = S_DONE;
                end
                S_DONE:  state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Strobe is withheld at 99 without wrap so the counter parks there.
    assign cnt_en     = counting && at_last && !terminal;
    assign cnt_rst    = cnt_rst_q;
    assign running    = counting;
    assign lap_active = (state_q == S_LAP);
    assign done       = (state_q == S_DONE);
    assign disp_q10   = lap_active ? lap_q[7:4] : cnt_q10;
    assign disp_q1    = lap_active ? lap_q[3:0] : cnt_q1;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - self-checking bench for stopwatch_ctrl, WRAP=0 and WRAP=1 side by side
module tb_stopwatch_ctrl;

    localparam int TICK = 4;
    localparam int M_IDLE = 10, M_RUN = 11, M_PAUSE = 12, M_LAP = 13, M_DONE = 14;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, b_ss, b_lap, b_clr;
    logic [3:0] q1 [2];
    logic [3:0] q10[2];
    logic [3:0] d1 [2];
    logic [3:0] d10[2];
    logic cnt_en[2], cnt_rst[2], running[2], lap_active[2], done[2];

    stopwatch_ctrl #(.TICK_DIV(TICK), .WRAP(1'b0)) dut0 (
        .clk(clk), .rst(rst), .btn_start_stop(b_ss), .btn_lap(b_lap), .btn_clear(b_clr),
        .cnt_q1(q1[0]), .cnt_q10(q10[0]), .cnt_en(cnt_en[0]), .cnt_rst(cnt_rst[0]),
        .disp_q1(d1[0]), .disp_q10(d10[0]), .running(running[0]),
        .lap_active(lap_active[0]), .done(done[0])
    );

    stopwatch_ctrl #(.TICK_DIV(TICK), .WRAP(1'b1)) dut1 (
        .clk(clk), .rst(rst), .btn_start_stop(b_ss), .btn_lap(b_lap), .btn_clear(b_clr),
        .cnt_q1(q1[1]), .cnt_q10(q10[1]), .cnt_en(cnt_en[1]), .cnt_rst(cnt_rst[1]),
        .disp_q1(d1[1]), .disp_q10(d10[1]), .running(running[1]),
        .lap_active(lap_active[1]), .done(done[1])
    );

    // Attached BCD counters, one per instance.
    initial begin
        q1[0] = 4'd0; q10[0] = 4'd0; q1[1] = 4'd0; q10[1] = 4'd0;
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (cnt_rst[i]) begin
                q1[i]  <= 4'd0;
                q10[i] <= 4'd0;
            end else if (cnt_en[i]) begin
                if (q1[i] == 4'd9) begin
                    q1[i]  <= 4'd0;
                    q10[i] <= (q10[i] == 4'd9) ? 4'd0 : q10[i] + 4'd1;
                end else begin
                    q1[i] <= q1[i] + 4'd1;
                end
            end
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    int m_mode[2], m_phase[2], m_count[2], m_lap[2];
    bit m_crst[2];
    bit p_ss, p_lap, p_clr;

    function automatic bit m_active(int i);
        return (m_mode[i] == M_RUN) || (m_mode[i] == M_LAP);
    endfunction

    function automatic bit m_term(int i);
        return (i == 0) && (m_count[i] == 99);
    endfunction

    function automatic bit m_en(int i);
        return m_active(i) && (m_phase[i] == TICK - 1) && !m_term(i);
    endfunction

    function automatic int to_bcd(int v);
        return ((v / 10) << 4) | (v % 10);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = M_IDLE; m_phase[i] = 0; m_lap[i] = 0; m_crst[i] = 1'b1; m_count[i] = 0;
        end
        p_ss = b_ss; p_lap = b_lap; p_clr = b_clr;
    endtask

    task automatic check_outputs();
        for (int i = 0; i < 2; i++) begin
            int shown;
            shown = (m_mode[i] == M_LAP) ? m_lap[i] : m_count[i];
            chk($sformatf("cnt_en[%0d]", i), int'(cnt_en[i]), int'(m_en(i)));
            chk($sformatf("cnt_rst[%0d]", i), int'(cnt_rst[i]), int'(m_crst[i]));
            chk($sformatf("disp[%0d]", i), int'({d10[i], d1[i]}), to_bcd(shown));
            chk($sformatf("running[%0d]", i), int'(running[i]), int'(m_active(i)));
            chk($sformatf("lap_active[%0d]", i), int'(lap_active[i]), int'(m_mode[i] == M_LAP));
            chk($sformatf("done[%0d]", i), int'(done[i]), int'(m_mode[i] == M_DONE));
        end
    endtask

    task automatic model_step();
        bit ps, pl, pc;
        ps = b_ss & ~p_ss;
        pl = b_lap & ~p_lap;
        pc = b_clr & ~p_clr;
        for (int i = 0; i < 2; i++) begin
            int n_count;
            bit term;
            term = m_term(i);
            if (m_crst[i])   n_count = 0;
            else if (m_en(i)) n_count = (m_count[i] + 1) % 100;
            else             n_count = m_count[i];
            if (rst) begin
                m_mode[i] = M_IDLE; m_phase[i] = 0; m_lap[i] = 0; m_crst[i] = 1'b1;
            end else begin
                m_crst[i] = 1'b0;
                if (m_active(i)) m_phase[i] = (m_phase[i] + 1) % TICK;
                if (pc) begin
                    m_mode[i] = M_IDLE; m_phase[i] = 0; m_lap[i] = 0; m_crst[i] = 1'b1;
                end else if (m_mode[i] == M_IDLE || m_mode[i] == M_PAUSE) begin
                    if (ps) m_mode[i] = M_RUN;
                end else if (m_mode[i] == M_RUN) begin
                    if (ps) m_mode[i] = M_PAUSE;
                    else if (pl) begin m_mode[i] = M_LAP; m_lap[i] = m_count[i]; end
                    else if (term) m_mode[i] = M_DONE;
                end else if (m_mode[i] == M_LAP) begin
                    if (ps) m_mode[i] = M_PAUSE;
                    else if (pl) m_mode[i] = M_RUN;
                    else if (term) m_mode[i] = M_DONE;
                end
            end
            m_count[i] = n_count;
        end
        p_ss = b_ss; p_lap = b_lap; p_clr = b_clr;
    endtask

    // Called 1ns after a rising edge; compares mid-cycle, advances the model, returns 1ns after the next edge.
    task automatic tick();
        #5;
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit ss;
        bit lap;
        bit clr;
        int n_wait;
        int disp;
        bit run;
        bit lapa;
        bit dn;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 1'b0,  40, 10, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0,   0, 10, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0,  20, 10, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0,   1, 10, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0,   4, 12, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0,  12, 12, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0,   0, 15, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 340, 99, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 1'b0,   5, 99, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b1,   1,  0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b0,   6,  1, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b1,   2,  0, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; b_ss = 1'b0; b_lap = 1'b0; b_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        repeat (3) tick();
        chk("reset_cnt_rst", int'(cnt_rst[0]), 1);
        chk("reset_disp", int'({d10[0], d1[0]}), 0);
        rst = 1'b0;
        tick();
        chk("cnt_rst_release", int'(cnt_rst[0]), 0);

        for (int v = 0; v < 12; v++) begin
            b_ss = vecs[v].ss; b_lap = vecs[v].lap; b_clr = vecs[v].clr;
            tick();
            b_ss = 1'b0; b_lap = 1'b0; b_clr = 1'b0;
            for (int w = 0; w < vecs[v].n_wait; w++) tick();
            chk($sformatf("vec%0d_disp", v), int'(d10[0]) * 10 + int'(d1[0]), vecs[v].disp);
            chk($sformatf("vec%0d_running", v), int'(running[0]), int'(vecs[v].run));
            chk($sformatf("vec%0d_lap_active", v), int'(lap_active[0]), int'(vecs[v].lapa));
            chk($sformatf("vec%0d_done", v), int'(done[0]), int'(vecs[v].dn));
        end

        // start_stop held high across reset must not start the watch.
        b_ss = 1'b1;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (4) tick();
        chk("held_through_rst_running", int'(running[0]), 0);
        chk("held_through_rst_running_wrap", int'(running[1]), 0);
        b_ss = 1'b0;
        tick();

        for (int c = 0; c < 6000; c++) begin
            if ($urandom_range(11) == 0) b_ss = ~b_ss;
            if ($urandom_range(15) == 0) b_lap = ~b_lap;
            b_clr = ($urandom_range(1499) == 0);
            rst   = ($urandom_range(2999) == 0);
            tick();
        end
        rst = 1'b0; b_ss = 1'b0; b_lap = 1'b0; b_clr = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
